// File: rtl/bram_pkg.sv
// Shared types and lane helpers for the configurable-width dual-port BRAM tile.
// Maps a port width plus the nibble-lane address onto nibble enables and a bit shift.
package bram_pkg;

  localparam int DATA_W  = 32;
  localparam int NIBBLES = 8;

  typedef enum logic [1:0] {
    W32 = 2'b00,
    W16 = 2'b01,
    W8  = 2'b10,
    W4  = 2'b11
  } width_e;

  typedef struct packed {
    logic [NIBBLES-1:0] nib_en;
    logic [4:0]         shift;
  } lane_t;

  function automatic lane_t lane_sel(width_e w, logic [2:0] sub);
    lane_t l;
    l.nib_en = '1;
    l.shift  = '0;
    case (w)
      W16: begin
        l.nib_en = 8'h0F << {sub[2], 2'b00};
        l.shift  = {sub[2], 4'b0000};
      end
      W8: begin
        l.nib_en = 8'h03 << {sub[2:1], 1'b0};
        l.shift  = {sub[2:1], 3'b000};
      end
      W4: begin
        l.nib_en = 8'h01 << sub;
        l.shift  = {sub, 2'b00};
      end
      default: ;
    endcase
    return l;
  endfunction

  function automatic logic [DATA_W-1:0] width_mask(width_e w);
    logic [DATA_W-1:0] m;
    case (w)
      W16:     m = 32'h0000_FFFF;
      W8:      m = 32'h0000_00FF;
      W4:      m = 32'h0000_000F;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl.sv
// FIFO bookkeeping for the BRAM tile: pointers, occupancy, registered flags and sticky errors.
// Also selects between FIFO pointers and fabric addresses for the shared memory array.
module bram_fifo_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int ALMOST_FULL  = 2**ADDR_W - 32,
  parameter int ALMOST_EMPTY = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_en,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] ram_waddr,
  input  logic [ADDR_W-1:0] ram_raddr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              afull_q, afull_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              mode_q;
  logic              flush, active, push, pop;

  // A mode change seen this cycle flushes state at the next edge and blocks FIFO traffic.
  assign flush  = fifo_en ^ mode_q;
  assign active = fifo_en & ~flush;
  assign push   = active & wr_en & (~full_q | rd_en);
  assign pop    = active & rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (active && wr_en && !push) ovf_d = 1'b1;
      if (active && rd_en && !pop)  udf_d = 1'b1;
    end
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (int'(count_d) >= ALMOST_FULL);
    aempty_d = (int'(count_d) <= ALMOST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      mode_q   <= fifo_en;
    end
  end

  assign mem_we       = fifo_en ? push : wr_en;
  assign mem_re       = fifo_en ? pop : rd_en;
  assign mem_waddr    = fifo_en ? wr_ptr_q : ram_waddr;
  assign mem_raddr    = fifo_en ? rd_ptr_q : ram_raddr;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: rtl/bram_cfg_dp.sv
// Simple-dual-port BRAM tile with per-port aspect ratios, optional output register and FIFO mode.
// Memory is read-first and uninitialised; only the read pipeline and FIFO state are reset.
module bram_cfg_dp
  import bram_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int ALMOST_FULL  = 2**ADDR_W - 32,
  parameter int ALMOST_EMPTY = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cfg_wr_width,
  input  logic [1:0]          cfg_rd_width,
  input  logic                cfg_reg_out,
  input  logic                cfg_fifo_en,
  input  logic                wr_en,
  input  logic [ADDR_W+2:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W+2:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                fifo_almost_full,
  output logic                fifo_almost_empty,
  output logic [ADDR_W:0]     fifo_count,
  output logic                fifo_ovf,
  output logic                fifo_udf,
  input  logic                err_clr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  width_e            wr_w, rd_w;
  lane_t             wlane, rlane;
  logic [DATA_W-1:0] wdata_sh, rd_ext;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic              valid1_q, valid2_q;

  bram_fifo_ctrl #(
    .ADDR_W       (ADDR_W),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  ) u_fifo_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_en      (cfg_fifo_en),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .ram_waddr    (wr_addr[ADDR_W+2:3]),
    .ram_raddr    (rd_addr[ADDR_W+2:3]),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .almost_full  (fifo_almost_full),
    .almost_empty (fifo_almost_empty),
    .ovf          (fifo_ovf),
    .udf          (fifo_udf)
  );

  // FIFO traffic is always full-word, so the width configuration is overridden there.
  assign wr_w     = cfg_fifo_en ? W32 : width_e'(cfg_wr_width);
  assign rd_w     = cfg_fifo_en ? W32 : width_e'(cfg_rd_width);
  assign wlane    = lane_sel(wr_w, wr_addr[2:0]);
  assign rlane    = lane_sel(rd_w, rd_addr[2:0]);
  assign wdata_sh = wr_data << wlane.shift;
  assign rd_ext   = (mem[mem_raddr] >> rlane.shift) & width_mask(rd_w);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (wlane.nib_en[i]) mem[mem_waddr][4*i +: 4] <= wdata_sh[4*i +: 4];
      end
    end
  end

  always_comb begin
    data1_d = data1_q;
    data2_d = data2_q;
    if (mem_re)   data1_d = rd_ext;
    if (valid1_q) data2_d = data1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q  <= '0;
      data2_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      valid1_q <= mem_re;
      valid2_q <= valid1_q;
    end
  end

  assign rd_data  = cfg_reg_out ? data2_q : data1_q;
  assign rd_valid = cfg_reg_out ? valid2_q : valid1_q;

endmodule

// File: doc/bram_cfg_dp.md
Name: bram_cfg_dp

Overview:
Parametrised simple-dual-port block RAM tile primitive. It is the next generation of the fabric's fixed 1 KB BRAM, with these additions:
- configurable depth;
- independent read/write aspect ratios (32/16/8/4 bit);
- optional output register;
- a built-in synchronous FIFO mode with flags, count and sticky error bits.

It sits as a BB-column tile primitive driven from fabric routing; configuration inputs come from tile config bits.

Parameters:
ADDR_W, 8, word-address width; depth = 2**ADDR_W words of 32 bits (default 1 KB)
ALMOST_FULL, 2**ADDR_W-32, fifo_almost_full asserts when count >= this value
ALMOST_EMPTY, 32, fifo_almost_empty asserts when count <= this value

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cfg_wr_width  in  2  write port width: 00=32, 01=16, 10=8, 11=4 bits
cfg_rd_width  in  2  read port width, same encoding
cfg_reg_out  in  1  1 = extra output register stage
cfg_fifo_en  in  1  1 = FIFO mode (32-bit only; width cfgs ignored)
wr_en  in  1  RAM: write strobe; FIFO: push
wr_addr  in  ADDR_W+3  [ADDR_W+2:3] word, [2:0] nibble-lane address; ignored in FIFO
wr_data  in  32  narrow writes take LSBs
rd_en  in  1  RAM: read strobe; FIFO: pop
rd_addr  in  ADDR_W+3  same format as wr_addr; ignored in FIFO
rd_data  out  32  read data, narrow reads right-aligned, upper bits 0
rd_valid  out  1  rd_data valid this cycle
fifo_full  out  1
fifo_empty  out  1
fifo_almost_full  out  1
fifo_almost_empty  out  1
fifo_count  out  ADDR_W+1  occupancy 0..2**ADDR_W
fifo_ovf  out  1  sticky: push while full without pop
fifo_udf  out  1  sticky: pop while empty
err_clr  in  1  synchronous clear of fifo_ovf/fifo_udf

Behaviour:
Reset (async assert, sync deassert):
- rd_data=0, rd_valid=0.
- Pointers and count = 0; fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0.
- ovf=udf=0.
- Memory contents are not reset.
- An operation in flight at reset is discarded.

Config inputs are static during operation. Any edge on cfg_fifo_en flushes the FIFO next cycle: pointers and count go to 0, and sticky bits are cleared.

RAM mode:
- Lane index for width W is addr[2:0] >> log2(W/4). 32-bit mode ignores addr[2:0].
- A write updates only the selected W-bit lane (internal nibble enables); all other bits are unchanged.
- Read latency is 1 cycle after rd_en, or 2 cycles with cfg_reg_out=1. rd_valid follows the same pipeline.
- With rd_en=0, rd_data holds its last value.
- Same-cycle read and write to an overlapping word is read-first: the old data is returned.
- Mixed widths are legal, e.g. write 8-bit, read 32-bit.

FIFO mode:
- Push accepted iff wr_en && (!full || rd_en). Pop accepted iff rd_en && !empty.
- Simultaneous push+pop on a full FIFO: both accepted, count unchanged.
- Simultaneous push+pop on an empty FIFO: push accepted, pop ignored, udf set.
- Rejected push sets ovf; rejected pop sets udf. err_clr has priority over a same-cycle set.
- Popped data appears on rd_data with the RAM-mode latency; rd_valid marks it.
- Pointers wrap modulo 2**ADDR_W. Full = count==2**ADDR_W.
- All flags are registered and update in the same cycle as fifo_count.

Decomposition:
- bram_pkg:
  - DATA_W=32, NIBBLES=8;
  - width enum (W32, W16, W8, W4);
  - function mapping width + addr[2:0] to a nibble-enable mask and lane shift.
- Sub-module bram_fifo_ctrl:
  - pointers, count, flags, sticky errors;
  - outputs the effective memory addresses and write/read enables to the top-level array/mux.

Test Plan:
- Write 0xDEADBEEF @ word 5 (32-bit), read word 5 with cfg_reg_out=0 -> rd_data=0xDEADBEEF, rd_valid 1 cycle after rd_en; with cfg_reg_out=1 -> 2 cycles.
- Mixed width: cfg_wr_width=10, write 0xA5 to byte lanes 0..3 of word 7 (addr[2:0]=0,2,4,6); 32-bit read -> 0xA5A5A5A5. Then cfg_rd_width=11, read lane 3 (addr[2:0]=3) -> 0x0000000A.
- Read-first: same-cycle write 0x1 / read of word 9 previously holding 0x2 -> rd_data=0x2; next read -> 0x1.
- FIFO fill, ADDR_W=4: 16 pushes of 0..15 -> fifo_full=1, count=16. A 17th push -> ovf=1, count stays 16. Push+pop while full -> count 16, pop returns 0.
- FIFO drain: 16 pops -> data 0..15 in order, then fifo_empty=1. An extra pop -> udf=1, rd_valid=0. err_clr -> ovf=udf=0.
- Reset mid-stream: rst_n low after 5 pushes -> count=0, empty=1, rd_data=0 immediately (async); after release, push 0x33 then pop -> 0x33.
